// File: rtl/div_unit.sv
// Sequential signed divider: non-restoring radix-2, one quotient bit per clock.
// Returns {remainder, quotient} in the same HI/LO layout as the ALU's 64-bit product.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic                 div0
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        FIX
    } state_t;

    state_t               state_q;
    logic [WIDTH:0]       r_q;          // signed partial remainder, one guard bit
    logic [WIDTH:0]       d_q;          // |B|, zero-extended
    logic [WIDTH-1:0]     q_q;          // |A| shifting out, quotient shifting in
    logic [CNT_W-1:0]     cnt_q;
    logic                 neg_rem_q;
    logic                 neg_quo_q;
    logic                 div0_pend_q;
    logic                 busy_q;
    logic                 done_q;
    logic [2*WIDTH-1:0]   result_q;
    logic                 div0_q;

    logic [WIDTH-1:0]     a_abs;
    logic [WIDTH-1:0]     b_abs;
    logic [WIDTH:0]       r_shift;
    logic [WIDTH:0]       r_step_d;
    logic [WIDTH-1:0]     q_step_d;
    logic [WIDTH:0]       r_fix;
    logic [WIDTH-1:0]     quo_fix_d;
    logic [WIDTH-1:0]     rem_fix_d;
    logic [WIDTH-1:0]     a_back_d;

    // Magnitudes are unsigned, so |0x80000000| = 0x80000000 stays exact.
    always_comb begin
        a_abs     = dividend[WIDTH-1] ? -dividend : dividend;
        b_abs     = divisor[WIDTH-1]  ? -divisor  : divisor;
        r_shift   = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
        r_step_d  = r_q[WIDTH] ? (r_shift + d_q) : (r_shift - d_q);
        q_step_d  = {q_q[WIDTH-2:0], ~r_step_d[WIDTH]};
        r_fix     = r_q[WIDTH] ? (r_q + d_q) : r_q;
        quo_fix_d = neg_quo_q ? -q_q : q_q;
        rem_fix_d = neg_rem_q ? -r_fix[WIDTH-1:0] : r_fix[WIDTH-1:0];
        // On divide-by-zero Q still holds |A|; re-applying the sign restores A.
        a_back_d  = neg_rem_q ? -q_q : q_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            r_q         <= '0;
            d_q         <= '0;
            q_q         <= '0;
            cnt_q       <= '0;
            neg_rem_q   <= 1'b0;
            neg_quo_q   <= 1'b0;
            div0_pend_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= '0;
            div0_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        neg_rem_q   <= dividend[WIDTH-1];
                        neg_quo_q   <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        q_q         <= a_abs;
                        d_q         <= {1'b0, b_abs};
                        r_q         <= '0;
                        cnt_q       <= '0;
                        busy_q      <= 1'b1;
                        div0_pend_q <= (divisor == '0);
                        state_q     <= (divisor == '0) ? FIX : ITER;
                    end
                end
                ITER: begin
                    r_q   <= r_step_d;
                    q_q   <= q_step_d;
                    cnt_q <= cnt_q + CNT_ONE;
                    if (cnt_q == LAST_STEP) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    if (div0_pend_q) begin
                        result_q <= {a_back_d, {WIDTH{1'b1}}};
                    end else begin
                        result_q <= {rem_fix_d, quo_fix_d};
                    end
                    div0_q  <= div0_pend_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign div0   = div0_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed and random checks of div_unit: results, latency, div0, handshake and reset.
module tb_div_unit;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy;
    logic        done;
    logic [63:0] result;
    logic        div0;

    int checks = 0;
    int errors = 0;
    logic done_prev = 1'b0;

    div_unit #(.WIDTH(32)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .div0     (div0)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // done must never be wider than one cycle
    always @(negedge clock) begin
        if (done === 1'b1) begin
            checks++;
            assert (done_prev === 1'b0) else begin
                errors++;
                $error("FAIL done_width: observed 2+ cycles expected 1");
            end
        end
        done_prev = done;
    end

    // Issue one operation; optionally pulse a spurious start at cycle inj.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp_res, input logic exp_d0,
                         input int exp_lat, input int inj);
        int k;
        int busy_cnt;
        @(negedge clock);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clock);
        #1;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        k        = 1;
        busy_cnt = 0;
        while (done !== 1'b1 && k < 100) begin
            if (busy === 1'b1) busy_cnt++;
            if (k == inj) begin
                start    = 1'b1;
                dividend = 32'd77;
                divisor  = 32'd0;
            end else if (k == inj + 1) begin
                start = 1'b0;
            end
            @(posedge clock);
            #1;
            k++;
        end
        $display("op %h / %h -> result %h div0 %0b latency %0d", a, b, result, div0, k);
        check("latency", 64'(k), 64'(exp_lat));
        check("busy_cycles", 64'(busy_cnt), 64'(exp_lat - 1));
        check("busy_at_done", {63'd0, busy}, 64'd0);
        check("result", result, exp_res);
        check("div0", {63'd0, div0}, {63'd0, exp_d0});
    endtask

    initial begin
        int k;
        int sa;
        int sb;
        int eq;
        int er;
        logic [31:0] ra;
        logic [31:0] rb;

        #12;
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_result", result, 64'd0);
        check("reset_div0", {63'd0, div0}, 64'd0);
        @(negedge clock);
        reset_n = 1'b1;

        do_op(32'd100, 32'd7, {32'h00000002, 32'h0000000E}, 1'b0, 34, 0);
        do_op(-32'sd100, 32'd7, {32'hFFFFFFFE, 32'hFFFFFFF2}, 1'b0, 34, 0);
        do_op(32'd100, -32'sd7, {32'h00000002, 32'hFFFFFFF2}, 1'b0, 34, 0);
        do_op(-32'sd100, -32'sd7, {32'hFFFFFFFE, 32'h0000000E}, 1'b0, 34, 0);
        do_op(32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 1'b0, 34, 0);
        do_op(32'h80000000, 32'd1, {32'h0, 32'h80000000}, 1'b0, 34, 0);
        do_op(32'd0, 32'd5, 64'd0, 1'b0, 34, 0);
        do_op(32'd7, 32'd100, {32'd7, 32'd0}, 1'b0, 34, 0);
        do_op(32'd5, 32'd0, {32'h00000005, 32'hFFFFFFFF}, 1'b1, 2, 0);
        do_op(-32'sd9, 32'd0, {32'hFFFFFFF7, 32'hFFFFFFFF}, 1'b1, 2, 0);
        do_op(32'd9, 32'd3, {32'd0, 32'd3}, 1'b0, 34, 0);

        // Spurious start at cycle 10 must not disturb the operation in flight.
        do_op(32'd1000, 32'd10, {32'd0, 32'd100}, 1'b0, 34, 10);

        // start held high: the edge ending the done cycle accepts the next op.
        @(negedge clock);
        start    = 1'b1;
        dividend = 32'd40;
        divisor  = 32'd6;
        @(posedge clock);
        #1;
        k = 1;
        while (done !== 1'b1 && k < 100) begin
            @(posedge clock);
            #1;
            k++;
        end
        $display("op b2b#1 40 / 6 -> result %h latency %0d", result, k);
        check("b2b_lat1", 64'(k), 64'd34);
        check("b2b_res1", result, {32'd4, 32'd6});
        @(posedge clock);
        #1;
        check("b2b_busy_next", {63'd0, busy}, 64'd1);
        check("b2b_result_held", result, {32'd4, 32'd6});
        start = 1'b0;
        k = 1;
        while (done !== 1'b1 && k < 100) begin
            @(posedge clock);
            #1;
            k++;
        end
        $display("op b2b#2 40 / 6 -> result %h latency %0d", result, k);
        check("b2b_lat2", 64'(k), 64'd34);
        check("b2b_res2", result, {32'd4, 32'd6});

        // Reset in the middle of an operation.
        @(negedge clock);
        start    = 1'b1;
        dividend = 32'd100;
        divisor  = 32'd7;
        @(posedge clock);
        #1;
        start = 1'b0;
        for (int i = 1; i < 15; i++) begin
            @(posedge clock);
            #1;
        end
        reset_n = 1'b0;
        #1;
        $display("op reset mid-flight -> busy %0b done %0b result %h div0 %0b", busy, done, result, div0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_result", result, 64'd0);
        check("rst_div0", {63'd0, div0}, 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        do_op(32'd100, 32'd7, {32'h00000002, 32'h0000000E}, 1'b0, 34, 0);

        // Random signed pairs against the language's truncating / and %.
        for (int n = 0; n < 200; n++) begin
            ra = $urandom;
            rb = (n % 2 == 0) ? $urandom : 32'($urandom_range(1, 300));
            if (n % 4 == 1) rb = -rb;
            if (n == 7) begin
                ra = 32'h80000000;
                rb = 32'hFFFFFFFF;
            end
            if (rb == 32'd0) rb = 32'd1;
            sa = ra;
            sb = rb;
            if (sa == int'(32'h80000000) && sb == -1) begin
                eq = sa;
                er = 0;
            end else begin
                eq = sa / sb;
                er = sa % sb;
            end
            do_op(ra, rb, {32'(er), 32'(eq)}, 1'b0, 34, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
